// File: rtl/otp_frame_packer.sv
// otp_frame_packer: buffers {pad index, ciphertext byte} pairs in a small FIFO
// and emits framed packets (sync, index, payload bytes, XOR checksum) on a
// ready/valid link that may stall.
module otp_frame_packer #(
    parameter int unsigned PAYLOAD_LEN = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    input  logic [2:0]    in_index,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1)  ? $clog2(FIFO_DEPTH)  : 1;
    localparam int unsigned BW = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_IDX     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [10:0]   mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          full_r;
    logic          overflow_r;
    logic          push_s;
    logic          drop_s;
    logic          pop_s;

    // Frame FSM state and registered outputs
    state_t        state_r;
    state_t        state_s;
    logic          out_valid_r;
    logic          out_valid_s;
    logic [7:0]    out_data_r;
    logic [7:0]    out_data_s;
    logic          out_last_r;
    logic          out_last_s;
    logic [7:0]    csum_r;
    logic [7:0]    csum_s;
    logic [BW-1:0] byte_cnt_r;
    logic [BW-1:0] byte_cnt_s;
    logic          hs_s;
    logic [10:0]   head_s;
    logic [7:0]    next_head_data_s;

    // Pointer increment with explicit wrap so any depth works
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(FIFO_DEPTH - 1)) begin
            ptr_inc = {AW{1'b0}};
        end else begin
            ptr_inc = p + AW'(1);
        end
    endfunction

    assign push_s           = ena && in_valid && !full_r;
    assign drop_s           = ena && in_valid && full_r;
    assign head_s           = mem_r[rd_ptr_r];
    assign next_head_data_s = mem_r[ptr_inc(rd_ptr_r)][7:0];

    assign in_ready   = !full_r && ena;
    assign out_valid  = out_valid_r && ena;
    assign out_data   = out_data_r;
    assign out_last   = out_last_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

    // Next FIFO occupancy from this cycle's push/pop
    always_comb begin
        count_s = count_r + CW'(push_s) - CW'(pop_s);
    end

    // FIFO entry write; contents need no reset because pointers gate reads
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_index, in_data};
        end
    end

    // FIFO pointers, occupancy, registered full flag and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            count_r <= count_s;
            full_r  <= (count_s == CW'(FIFO_DEPTH));
            if (drop_s) overflow_r <= 1'b1;
        end
    end

    // Frame FSM next state, next registered outputs and FIFO pop
    always_comb begin
        state_s     = state_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_last_s  = out_last_r;
        csum_s      = csum_r;
        byte_cnt_s  = byte_cnt_r;
        pop_s       = 1'b0;
        hs_s        = out_valid_r && out_ready;
        if (ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (count_r >= CW'(PAYLOAD_LEN)) begin
                        state_s     = ST_SYNC;
                        out_valid_s = 1'b1;
                        out_data_s  = SYNC_BYTE;
                        out_last_s  = 1'b0;
                    end else begin
                        out_valid_s = 1'b0;
                    end
                end
                ST_SYNC: begin
                    if (hs_s) begin
                        state_s    = ST_IDX;
                        out_data_s = {5'b00000, head_s[10:8]};
                        csum_s     = {5'b00000, head_s[10:8]};
                    end else begin
                        state_s = ST_SYNC;
                    end
                end
                ST_IDX: begin
                    if (hs_s) begin
                        state_s    = ST_PAYLOAD;
                        out_data_s = head_s[7:0];
                        byte_cnt_s = {BW{1'b0}};
                    end else begin
                        state_s = ST_IDX;
                    end
                end
                ST_PAYLOAD: begin
                    if (hs_s) begin
                        pop_s  = 1'b1;
                        csum_s = csum_r ^ head_s[7:0];
                        if (byte_cnt_r == BW'(PAYLOAD_LEN - 1)) begin
                            state_s    = ST_CSUM;
                            out_data_s = csum_r ^ head_s[7:0];
                            out_last_s = 1'b1;
                        end else begin
                            out_data_s = next_head_data_s;
                            byte_cnt_s = byte_cnt_r + BW'(1);
                        end
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end
                ST_CSUM: begin
                    if (hs_s) begin
                        state_s     = ST_IDLE;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                    end else begin
                        state_s = ST_CSUM;
                    end
                end
                default: begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                    out_last_s  = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Frame FSM state and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            csum_r      <= 8'h00;
            byte_cnt_r  <= {BW{1'b0}};
        end else begin
            state_r     <= state_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_last_r  <= out_last_s;
            csum_r      <= csum_s;
            byte_cnt_r  <= byte_cnt_s;
        end
    end

endmodule

// File: doc/otp_frame_packer.md
Name: otp_frame_packer

Overview:
- Downstream stage of the one-time-pad encryptor. Consumes each ciphertext byte together with its 3-bit pad index, and buffers them in a small FIFO.
- Emits framed byte packets on a ready/valid output port for the transport link. Frame format: sync byte, index byte, PAYLOAD_LEN ciphertext bytes, then an XOR checksum byte.
- Decouples the encryptor's one-byte-per-cycle production from a link that can stall.

Parameters:
- PAYLOAD_LEN, 4, ciphertext bytes per frame; legal range 1..8.
- FIFO_DEPTH, 8, input FIFO entries; power of two, at least PAYLOAD_LEN.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- ena  input  1  block enable; low freezes the block.
- in_valid  input  1  in_data/in_index are valid this cycle.
- in_ready  output  1  FIFO can accept a byte (equals !full && ena).
- in_data  input  8  ciphertext byte.
- in_index  input  3  pad index used for in_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  8  frame byte.
- out_last  output  1  high with the checksum byte only.
- fifo_count  output  CW  FIFO occupancy, CW = clog2(FIFO_DEPTH)+1.
- overflow  output  1  sticky flag: a byte was dropped.

Behaviour:
Reset (rst_n low at a clk edge):
- State goes to IDLE and the FIFO pointers and fifo_count clear to 0.
- out_valid, out_data, out_last, overflow and the checksum register all clear to 0.
- Reset mid-frame aborts the frame. No checksum byte is emitted and the partial frame is discarded.

Input side:
- Push when ena && in_valid && !full; the FIFO stores {in_index, in_data}.
- If ena && in_valid && full, the byte is dropped and overflow is set. overflow clears only on reset.
- Push and pop in the same cycle leave fifo_count unchanged.
- A pop that frees space does not raise in_ready in the same cycle, because full is registered.

Output FSM. out_valid, out_data and out_last are registered outputs.
- IDLE: out_valid=0. When ena && fifo_count >= PAYLOAD_LEN, go to SYNC on the next edge, driving out_data=SYNC_BYTE and out_valid=1.
- SYNC: on handshake (out_valid && out_ready) go to IDX.
  - out_data = {5'b0, index of the FIFO head entry}.
  - csum is loaded with that index byte.
- IDX: on handshake go to PAYLOAD, with out_data = the FIFO head data.
- PAYLOAD:
  - Each handshake pops the FIFO head and XORs it into csum.
  - The next head byte is presented until PAYLOAD_LEN bytes have been accepted.
  - After the last payload byte, go to CSUM with out_data = final csum and out_last=1.
- CSUM: on handshake go to IDLE with out_valid=0 and out_last=0. The minimum inter-frame gap is one cycle.
- Frame length is PAYLOAD_LEN+3 bytes.
- Latency: with the FIFO already holding PAYLOAD_LEN entries and out_ready=1, SYNC appears one cycle after entering IDLE, and the frame completes in PAYLOAD_LEN+3 consecutive cycles.
- Checksum = index byte XOR all payload bytes of the frame.

Backpressure:
- While out_valid && !out_ready, out_data, out_last and state must hold stable.
- No byte is lost or duplicated.

ena=0:
- in_ready=0 and the FSM, FIFO and csum hold.
- out_valid is forced to 0 and out_ready is ignored.
- When ena returns, the same pending byte is re-presented.

Frame content and wrap-around:
- The index byte uses the index of the first payload byte only. Later indices are stored in the FIFO but not emitted.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.

Test Plan:
1. Single frame, all defaults:
   - Stimulus: push 0x11, 0x22, 0x33, 0x44 with indices 0..3; out_ready=1.
   - Response: A5, 00, 11, 22, 33, 44, 44 on consecutive cycles, with out_last only on the final 0x44.
2. Second frame:
   - Stimulus: push F0, 0F, AA, 55 with indices 4..7.
   - Response: A5, 04, F0, 0F, AA, 55, 04.
3. Backpressure:
   - Stimulus: repeat scenario 1 with out_ready toggling 1,0,0,1,...
   - Response: identical byte sequence; out_data stable during every stall.
4. Overflow:
   - Stimulus: out_ready=0 and push 8 bytes.
   - Response: fifo_count=8 and in_ready=0.
   - Stimulus: push a 9th byte.
   - Response: overflow=1 and the byte is dropped. With out_ready=1, exactly two 7-byte frames of the first 8 bytes follow.
5. Underfill and enable:
   - Stimulus: push 3 bytes.
   - Response: out_valid stays 0.
   - Stimulus: push a 4th byte, then drop ena for 3 cycles mid-PAYLOAD.
   - Response: output freezes with out_valid=0, then resumes with the byte that was pending and the correct checksum.
6. Reset mid-frame:
   - Stimulus: assert rst_n=0 during PAYLOAD.
   - Response: after the edge, out_valid=0, fifo_count=0, overflow=0 and out_last=0. A new 4-byte push produces a fresh, correct frame.
